fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx.sv | 111 +++++++++++
 tb/tb_fifo_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port and UART line bundle for fifo_uart_tx
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              read_en;
    logic              tx;
    logic              busy;
    logic              frame_done;

    // master is the serialiser: it pops the FIFO and drives the line
    modport master (
        input  enable, fifo_empty, fifo_data,
        output read_en, tx, busy, frame_done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  read_en, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain that pops bytes and sends them as 8N1 UART frames
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_uart_tx_if.master bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              read_en_q;
    logic              tx_q;
    logic              busy_q;
    logic              frame_done_q;

    assign bus.read_en    = read_en_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            read_en_q    <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            read_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    // enable is only looked at here, so dropping it mid-frame never truncates a frame
                    if (bus.enable && !bus.fifo_empty) begin
                        state     <= POP;
                        read_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                POP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    // FIFO data_out is valid the cycle after the pop strobe was sampled
                    shreg    <= bus.fifo_data;
                    baud_cnt <= '0;
                    tx_q     <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx_q    <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // raised one cycle early so the registered pulse lands on the last STOP cycle
                    if (baud_cnt == BAUD_PRELAST) begin
                        frame_done_q <= 1'b1;
                    end
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_W(8)) if4 ();
    fifo_uart_tx_if #(.DATA_W(8)) if16 ();

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.master)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(16), .DATA_W(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.master)
    );

    // FIFO models: data_out updates on the edge that samples read_en
    logic [7:0] mem4 [16];
    logic [7:0] mem16 [16];
    int wr4 = 0, rd4 = 0, wr16 = 0, rd16 = 0;

    assign if4.fifo_empty  = (rd4 == wr4);
    assign if16.fifo_empty = (rd16 == wr16);

    always @(posedge clk) begin
        if (if4.read_en) begin
            if4.fifo_data <= mem4[rd4 % 16];
            rd4 <= rd4 + 1;
        end
        if (if16.read_en) begin
            if16.fifo_data <= mem16[rd16 % 16];
            rd16 <= rd16 + 1;
        end
    end

    int   pulses4 = 0;
    int   double_re = 0;
    logic prev_re4 = 1'b0, prev_re16 = 1'b0;

    always @(negedge clk) begin
        if (if4.read_en) pulses4 <= pulses4 + 1;
        if ((if4.read_en && prev_re4) || (if16.read_en && prev_re16)) double_re <= double_re + 1;
        prev_re4  <= if4.read_en;
        prev_re16 <= if16.read_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] expand(input logic [9:0] lv);
        logic [39:0] r;
        for (int i = 0; i < 40; i++) r[i] = lv[i / 4];
        return r;
    endfunction

    task automatic push4(input logic [7:0] b);
        mem4[wr4 % 16] = b;
        wr4++;
    endtask

    task automatic push16(input logic [7:0] b);
        mem16[wr16 % 16] = b;
        wr16++;
    endtask

    task automatic wait_pop4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (if4.read_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_start4(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (if4.tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // first sample is the current negedge (first START cycle)
    task automatic capture4(input int drop_at, output logic [39:0] txs, output int fd_cnt,
                            output int fd_pos, output logic busy_all);
        fd_cnt   = 0;
        fd_pos   = -1;
        busy_all = 1'b1;
        txs      = '0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (i == drop_at) if4.enable = 1'b0;
            txs[i] = if4.tx;
            if (if4.frame_done) begin
                fd_cnt++;
                fd_pos = i;
            end
            if (!if4.busy) busy_all = 1'b0;
        end
    endtask

    task automatic rx16(output logic [7:0] d, output logic [1:0] framing, output bit found);
        d       = '0;
        framing = '0;
        found   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (if16.tx == 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) return;
        repeat (7) @(negedge clk);
        framing[1] = ~if16.tx;
        for (int b = 0; b < 8; b++) begin
            repeat (16) @(negedge clk);
            d[b] = if16.tx;
        end
        repeat (16) @(negedge clk);
        framing[0] = if16.tx;
    endtask

    initial begin
        logic [39:0] txs;
        logic [7:0]  rx_byte;
        logic [1:0]  framing;
        logic        busy_all;
        logic        bad_tx, bad_busy;
        int          fd_cnt, fd_pos, n, base;
        bit          ok;

        rst_n        = 1'b0;
        if4.enable   = 1'b0;
        if16.enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", if4.tx, 1'b1);
        check("rst_read_en", if4.read_en, 1'b0);
        check("rst_busy", if4.busy, 1'b0);
        check("rst_frame_done", if4.frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte 0x0A
        base = pulses4;
        push4(8'h0A);
        if4.enable = 1'b1;
        wait_pop4(ok);
        check("single_pop_seen", ok, 1'b1);
        check("single_busy_pop", if4.busy, 1'b1);
        wait_start4(n, ok);
        check("single_start_seen", ok, 1'b1);
        check("single_latency", n, 2);
        capture4(-1, txs, fd_cnt, fd_pos, busy_all);
        check("single_frame", txs, expand(10'b1000010100));
        check("single_fd_count", fd_cnt, 1);
        check("single_fd_pos", fd_pos, 39);
        check("single_busy_span", busy_all, 1'b1);
        @(negedge clk);
        check("single_busy_after", if4.busy, 1'b0);
        check("single_tx_after", if4.tx, 1'b1);
        repeat (5) @(negedge clk);
        check("single_pulses", pulses4 - base, 1);

        // empty FIFO with enable held
        base     = pulses4;
        bad_tx   = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if4.tx !== 1'b1) bad_tx = 1'b1;
            if (if4.busy !== 1'b0) bad_busy = 1'b1;
        end
        check("empty_pulses", pulses4 - base, 0);
        check("empty_tx_low", bad_tx, 1'b0);
        check("empty_busy", bad_busy, 1'b0);

        // streaming 0x55 then 0xA3
        base = pulses4;
        push4(8'h55);
        push4(8'hA3);
        wait_start4(n, ok);
        check("stream_start1_seen", ok, 1'b1);
        capture4(-1, txs, fd_cnt, fd_pos, busy_all);
        check("stream_frame1", txs, expand(10'b1010101010));
        wait_start4(n, ok);
        check("stream_start2_seen", ok, 1'b1);
        check("stream_gap", n - 1, 3);
        capture4(-1, txs, fd_cnt, fd_pos, busy_all);
        check("stream_frame2", txs, expand(10'b1101000110));
        if4.enable = 1'b0;
        repeat (5) @(negedge clk);
        check("stream_pulses", pulses4 - base, 2);

        // enable dropped during DATA with two bytes queued
        base = pulses4;
        push4(8'h11);
        push4(8'h22);
        if4.enable = 1'b1;
        wait_start4(n, ok);
        check("drop_start_seen", ok, 1'b1);
        capture4(12, txs, fd_cnt, fd_pos, busy_all);
        check("drop_frame", txs, expand(10'b1000100010));
        repeat (20) @(negedge clk);
        check("drop_pulses", pulses4 - base, 1);
        check("drop_fifo_left", wr4 - rd4, 1);
        check("drop_tx_idle", if4.tx, 1'b1);
        check("drop_busy", if4.busy, 1'b0);

        // reset mid-DATA of 0x22 (bit 0 is 0)
        if4.enable = 1'b1;
        wait_start4(n, ok);
        check("mrst_start_seen", ok, 1'b1);
        repeat (5) @(negedge clk);
        check("mrst_tx_data", if4.tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_tx", if4.tx, 1'b1);
        check("mrst_read_en", if4.read_en, 1'b0);
        check("mrst_busy", if4.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base  = pulses4;
        bad_tx   = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if4.tx !== 1'b1) bad_tx = 1'b1;
            if (if4.busy !== 1'b0) bad_busy = 1'b1;
        end
        check("mrst_idle_pulses", pulses4 - base, 0);
        check("mrst_idle_tx", bad_tx, 1'b0);
        check("mrst_idle_busy", bad_busy, 1'b0);
        if4.enable = 1'b0;

        // mid-bit receiver on the 16x instance
        push16(8'h00);
        push16(8'hFF);
        push16(8'h81);
        if16.enable = 1'b1;
        rx16(rx_byte, framing, ok);
        check("rx_00_found", ok, 1'b1);
        check("rx_00_data", rx_byte, 8'h00);
        check("rx_00_framing", framing, 2'b11);
        rx16(rx_byte, framing, ok);
        check("rx_ff_found", ok, 1'b1);
        check("rx_ff_data", rx_byte, 8'hFF);
        check("rx_ff_framing", framing, 2'b11);
        rx16(rx_byte, framing, ok);
        check("rx_81_found", ok, 1'b1);
        check("rx_81_data", rx_byte, 8'h81);
        check("rx_81_framing", framing, 2'b11);
        if16.enable = 1'b0;
        repeat (20) @(negedge clk);

        check("read_en_double", double_re, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
